// File: rtl/color_write_ctrl.sv
// color_write_ctrl
// Sequences 4-byte colour commands (header, R, G, B) from the UART receiver
// into six nibble writes (addresses 3..8) on the colour register file, one
// write at a time. Each write waits for the register-file ack. Both the byte
// stream and the ack are guarded by timeouts.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rx_data   received byte, qualified by rx_valid
//   rx_valid  one-cycle strobe per received byte
//   ack       register-file write acknowledge
//   channel   target colour channel, held for the whole command
//   address   register-file nibble address (3..8)
//   data      nibble to write
//   valid     registered write request
//   busy      high from header accept until done or abort
//   done      one-cycle pulse after the sixth ack
//   err       sticky error flag (timeout or overrun), cleared by a header
module color_write_ctrl #(
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned BYTE_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       ack,
    output logic [1:0] channel,
    output logic [3:0] address,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GET_R, GET_G, GET_B, ISSUE, WAIT_ACK, GAP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    chan_q, chan_d;
    logic [3:0]    addr_q, addr_d;
    logic [3:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic [2:0]    n_q, n_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic [19:0]   byte_cnt_q, byte_cnt_d;

    function automatic logic [3:0] nibble_sel(input logic [2:0] n,
                                              input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
        case (n)
            3'd0:    nibble_sel = r[7:4];
            3'd1:    nibble_sel = r[3:0];
            3'd2:    nibble_sel = g[7:4];
            3'd3:    nibble_sel = g[3:0];
            3'd4:    nibble_sel = b[7:4];
            default: nibble_sel = b[3:0];
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        n_d        = n_q;
        ack_cnt_d  = ack_cnt_q;
        byte_cnt_d = byte_cnt_q;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data[7:4] == 4'hA) begin
                    chan_d     = rx_data[1:0];
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = GET_R;
                end
            end
            GET_R, GET_G, GET_B: begin
                if (rx_valid) begin
                    byte_cnt_d = '0;
                    if (state_q == GET_R) begin
                        r_d     = rx_data;
                        state_d = GET_G;
                    end else if (state_q == GET_G) begin
                        g_d     = rx_data;
                        state_d = GET_B;
                    end else begin
                        // valid is registered, so the first write is set up
                        // here so that it is already on the bus in ISSUE.
                        b_d       = rx_data;
                        n_d       = '0;
                        addr_d    = 4'd3;
                        data_d    = r_q[7:4];
                        valid_d   = 1'b1;
                        ack_cnt_d = '0;
                        state_d   = ISSUE;
                    end
                end else if (byte_cnt_q == 20'(BYTE_TIMEOUT - 1)) begin
                    busy_d     = 1'b0;
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 20'd1;
                end
            end
            ISSUE: begin
                ack_cnt_d = ack_cnt_q + AW'(1);
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    valid_d   = 1'b0;
                    ack_cnt_d = '0;
                    if (n_q == 3'd5) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        n_d     = n_q + 3'd1;
                        state_d = GAP;
                    end
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    // counter holds cycles of valid already seen, so valid
                    // drops after exactly ACK_TIMEOUT high cycles
                    valid_d   = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    ack_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            GAP: begin
                addr_d    = 4'd3 + {1'b0, n_q};
                data_d    = nibble_sel(n_q, r_q, g_q, b_q);
                valid_d   = 1'b1;
                ack_cnt_d = '0;
                state_d   = ISSUE;
            end
            default: state_d = IDLE;
        endcase

        // a byte arriving while writes are in flight is dropped and flagged
        if (rx_valid && (state_q == ISSUE || state_q == WAIT_ACK || state_q == GAP))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            n_q        <= '0;
            ack_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            n_q        <= n_d;
            ack_cnt_q  <= ack_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign channel = chan_q;
    assign address = addr_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
